// File: rtl/sys_ctrl_burst.sv
// System controller: decodes UART command frames, drives the register file and ALU,
// and serialises responses into the TX FIFO with back-pressure.
module sys_ctrl_burst #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDR_WIDTH    = 4,
    parameter int unsigned ALU_OUT_BYTES = 2,
    parameter int unsigned ALU_FUN_WIDTH = 4
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic [DATA_WIDTH-1:0]               RX_P_DATA,
    input  logic                                RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]               RdData,
    input  logic                                RdData_Valid,
    output logic                                WrEN,
    output logic                                RdEN,
    output logic [ADDR_WIDTH-1:0]               Address,
    output logic [DATA_WIDTH-1:0]               WrData,
    output logic                                ALU_EN,
    output logic [ALU_FUN_WIDTH-1:0]            ALU_FUN,
    input  logic [DATA_WIDTH*ALU_OUT_BYTES-1:0] ALU_OUT,
    input  logic                                ALU_OUT_VLD,
    output logic                                CLK_EN,
    output logic                                clk_div_en,
    input  logic                                FIFO_FULL,
    output logic [DATA_WIDTH-1:0]               WR_DATA,
    output logic                                WR_INC,
    output logic                                CMD_ERR
);

    localparam int unsigned RES_W = DATA_WIDTH * ALU_OUT_BYTES;
    localparam int unsigned TXC_W = $clog2(ALU_OUT_BYTES + 1);

    localparam logic [DATA_WIDTH-1:0] CMD_WR    = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD    = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU   = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_N = DATA_WIDTH'(8'hDD);
    localparam logic [DATA_WIDTH-1:0] CMD_BURST = DATA_WIDTH'(8'hEE);

    typedef enum logic [3:0] {
        ST_IDLE, ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR, ST_RD_WAIT,
        ST_OPA, ST_OPB, ST_FUN, ST_ALU_WAIT,
        ST_BR_ADDR, ST_BR_CNT, ST_BR_RD, ST_BR_WAIT, ST_TX
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [DATA_WIDTH-1:0]   wdata_d, wr_data_d;
    logic                    wr_en_d, rd_en_d, alu_en_d, clk_en_d, cmd_err_d;
    logic [ALU_FUN_WIDTH-1:0] alu_fun_d;
    logic                    tx_vld, tx_vld_d;
    logic [RES_W-1:0]        tx_buf, tx_buf_d;
    logic [TXC_W-1:0]        tx_left, tx_left_d;
    logic [DATA_WIDTH-1:0]   br_left, br_left_d;
    logic                    tx_push;

    // A push only happens in a cycle where the FIFO reports space, so FULL is honoured live.
    assign tx_push = tx_vld & ~FIFO_FULL;
    assign WR_INC  = tx_push;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            Address    <= '0;
            WrData     <= '0;
            WrEN       <= 1'b0;
            RdEN       <= 1'b0;
            ALU_EN     <= 1'b0;
            ALU_FUN    <= '0;
            CLK_EN     <= 1'b0;
            clk_div_en <= 1'b0;
            WR_DATA    <= '0;
            CMD_ERR    <= 1'b0;
            tx_vld     <= 1'b0;
            tx_buf     <= '0;
            tx_left    <= '0;
            br_left    <= '0;
        end else begin
            state_q    <= state_d;
            Address    <= addr_d;
            WrData     <= wdata_d;
            WrEN       <= wr_en_d;
            RdEN       <= rd_en_d;
            ALU_EN     <= alu_en_d;
            ALU_FUN    <= alu_fun_d;
            CLK_EN     <= clk_en_d;
            clk_div_en <= 1'b1;
            WR_DATA    <= wr_data_d;
            CMD_ERR    <= cmd_err_d;
            tx_vld     <= tx_vld_d;
            tx_buf     <= tx_buf_d;
            tx_left    <= tx_left_d;
            br_left    <= br_left_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = Address;
        wdata_d   = WrData;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        alu_en_d  = 1'b0;
        alu_fun_d = ALU_FUN;
        clk_en_d  = CLK_EN;
        wr_data_d = WR_DATA;
        cmd_err_d = 1'b0;
        tx_vld_d  = tx_vld;
        tx_buf_d  = tx_buf;
        tx_left_d = tx_left;
        br_left_d = br_left;

        unique case (state_q)
            ST_IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == CMD_WR)         state_d = ST_WR_ADDR;
                    else if (RX_P_DATA == CMD_RD)    state_d = ST_RD_ADDR;
                    else if (RX_P_DATA == CMD_ALU)   state_d = ST_OPA;
                    else if (RX_P_DATA == CMD_ALU_N) state_d = ST_FUN;
                    else if (RX_P_DATA == CMD_BURST) state_d = ST_BR_ADDR;
                    else                             cmd_err_d = 1'b1;
                end
            end
            ST_WR_ADDR: begin
                if (RX_D_VLD) begin
                    addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_d = ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                if (RX_D_VLD) begin
                    wdata_d = RX_P_DATA;
                    wr_en_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_RD_ADDR: begin
                if (RX_D_VLD) begin
                    addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                    rd_en_d = 1'b1;
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                cmd_err_d = RX_D_VLD;
                if (RdData_Valid) begin
                    wr_data_d = RdData;
                    tx_left_d = '0;
                    tx_vld_d  = 1'b1;
                    state_d   = ST_TX;
                end
            end
            // Operands land in the two lowest RF locations where the ALU reads them.
            ST_OPA: begin
                if (RX_D_VLD) begin
                    addr_d  = '0;
                    wdata_d = RX_P_DATA;
                    wr_en_d = 1'b1;
                    state_d = ST_OPB;
                end
            end
            ST_OPB: begin
                if (RX_D_VLD) begin
                    addr_d  = ADDR_WIDTH'(1);
                    wdata_d = RX_P_DATA;
                    wr_en_d = 1'b1;
                    state_d = ST_FUN;
                end
            end
            ST_FUN: begin
                if (RX_D_VLD) begin
                    alu_fun_d = RX_P_DATA[ALU_FUN_WIDTH-1:0];
                    alu_en_d  = 1'b1;
                    clk_en_d  = 1'b1;
                    state_d   = ST_ALU_WAIT;
                end
            end
            ST_ALU_WAIT: begin
                cmd_err_d = RX_D_VLD;
                if (ALU_OUT_VLD) begin
                    wr_data_d = ALU_OUT[DATA_WIDTH-1:0];
                    tx_buf_d  = ALU_OUT >> DATA_WIDTH;
                    tx_left_d = TXC_W'(ALU_OUT_BYTES - 1);
                    tx_vld_d  = 1'b1;
                    clk_en_d  = 1'b0;
                    state_d   = ST_TX;
                end
            end
            ST_BR_ADDR: begin
                if (RX_D_VLD) begin
                    addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_d = ST_BR_CNT;
                end
            end
            ST_BR_CNT: begin
                if (RX_D_VLD) begin
                    br_left_d = RX_P_DATA;
                    state_d   = (RX_P_DATA == '0) ? ST_IDLE : ST_BR_RD;
                end
            end
            ST_BR_RD: begin
                cmd_err_d = RX_D_VLD;
                rd_en_d   = 1'b1;
                state_d   = ST_BR_WAIT;
            end
            ST_BR_WAIT: begin
                cmd_err_d = RX_D_VLD;
                if (RdData_Valid) begin
                    wr_data_d = RdData;
                    tx_left_d = '0;
                    tx_vld_d  = 1'b1;
                    br_left_d = br_left - 1'b1;
                    state_d   = ST_TX;
                end
            end
            // Bytes go out LSB first; a burst resumes at the next (wrapping) address.
            ST_TX: begin
                cmd_err_d = RX_D_VLD;
                if (tx_push) begin
                    if (tx_left == '0) begin
                        tx_vld_d = 1'b0;
                        if (br_left != '0) begin
                            addr_d  = Address + 1'b1;
                            state_d = ST_BR_RD;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        wr_data_d = tx_buf[DATA_WIDTH-1:0];
                        tx_buf_d  = tx_buf >> DATA_WIDTH;
                        tx_left_d = tx_left - 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sys_ctrl_burst.sv
// Bench for sys_ctrl_burst: RF/ALU/FIFO environment plus a frame-level reference model.
module tb_sys_ctrl_burst;

    logic        CLK, RST;
    logic [7:0]  RX_P_DATA, RdData, WrData, WR_DATA;
    logic        RX_D_VLD, RdData_Valid, WrEN, RdEN, ALU_EN, ALU_OUT_VLD;
    logic        CLK_EN, clk_div_en, FIFO_FULL, WR_INC, CMD_ERR;
    logic [3:0]  Address, ALU_FUN;
    logic [15:0] ALU_OUT;

    sys_ctrl_burst dut (
        .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RdData(RdData), .RdData_Valid(RdData_Valid), .WrEN(WrEN), .RdEN(RdEN),
        .Address(Address), .WrData(WrData), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
        .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD), .CLK_EN(CLK_EN),
        .clk_div_en(clk_div_en), .FIFO_FULL(FIFO_FULL), .WR_DATA(WR_DATA),
        .WR_INC(WR_INC), .CMD_ERR(CMD_ERR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int checks = 0;
    int fails  = 0;
    logic [7:0] ref_mem [16];
    logic [7:0] rf_mem  [16];
    int exp_wr[$], exp_rd[$], exp_alu[$], exp_tx[$];
    int wr_i = 0, rd_i = 0, alu_i = 0, tx_i = 0, tx_seen = 0;
    int err_exp = 0, err_seen = 0;
    logic exp_clk = 1'b0, prev_vld = 1'b0;
    logic rd_req = 1'b0;
    logic [3:0] rd_addr = '0;
    int alu_cnt = 0;
    logic [15:0] alu_res = '0;
    logic rx_pend = 1'b0;
    logic [7:0] rx_byte = '0;
    logic ff_force = 1'b0, ff_rand = 1'b0;
    logic [7:0] frm[$];

    function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] f);
        case (f)
            4'd0:    return 16'(a) + 16'(b);
            4'd1:    return 16'(a) - 16'(b);
            4'd2:    return 16'(a) * 16'(b);
            4'd3:    return {8'h00, a & b};
            4'd4:    return {8'h00, a | b};
            default: return {8'h00, a ^ b};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    function automatic logic idle();
        return wr_i == exp_wr.size() && rd_i == exp_rd.size() && alu_i == exp_alu.size() &&
               tx_i == exp_tx.size() && err_seen == err_exp && alu_cnt == 0 &&
               !rd_req && !exp_clk;
    endfunction

    task automatic monitor();
        if (prev_vld) exp_clk = 1'b0;
        if (ALU_EN)   exp_clk = 1'b1;
        prev_vld = ALU_OUT_VLD;
        check("clk_en", 32'(CLK_EN), 32'(exp_clk));
        if (WrEN) begin
            check("wr_expected", 32'(wr_i < exp_wr.size()), 32'd1);
            if (wr_i < exp_wr.size()) begin
                check("wr_addr_data", 32'({Address, WrData}), 32'(exp_wr[wr_i]));
                wr_i++;
            end
            rf_mem[Address] = WrData;
        end
        if (RdEN) begin
            check("rd_expected", 32'(rd_i < exp_rd.size()), 32'd1);
            if (rd_i < exp_rd.size()) begin
                check("rd_addr", 32'(Address), 32'(exp_rd[rd_i]));
                rd_i++;
            end
            rd_req  = 1'b1;
            rd_addr = Address;
        end
        if (ALU_EN) begin
            check("alu_expected", 32'(alu_i < exp_alu.size()), 32'd1);
            if (alu_i < exp_alu.size()) begin
                check("alu_fun", 32'(ALU_FUN), 32'(exp_alu[alu_i]));
                alu_i++;
            end
            alu_res = alu_fn(rf_mem[0], rf_mem[1], ALU_FUN);
            alu_cnt = $urandom_range(2, 5);
        end
        if (WR_INC) begin
            tx_seen++;
            check("tx_expected", 32'(tx_i < exp_tx.size()), 32'd1);
            if (tx_i < exp_tx.size()) begin
                check("tx_byte", 32'(WR_DATA), 32'(exp_tx[tx_i]));
                tx_i++;
            end
        end
        if (FIFO_FULL) check("inc_while_full", 32'(WR_INC), 32'd0);
        if (CMD_ERR) begin
            err_seen++;
            check("cmd_err_expected", 32'(err_seen <= err_exp), 32'd1);
        end
    endtask

    // One clock: drive inputs just after the rising edge, observe at the falling edge.
    task automatic tick();
        @(posedge CLK);
        #1;
        RX_D_VLD = rx_pend;
        if (rx_pend) RX_P_DATA = rx_byte;
        rx_pend      = 1'b0;
        RdData_Valid = 1'b0;
        ALU_OUT_VLD  = 1'b0;
        if (rd_req) begin
            RdData       = rf_mem[rd_addr];
            RdData_Valid = 1'b1;
            rd_req       = 1'b0;
        end
        if (alu_cnt > 0) begin
            alu_cnt--;
            if (alu_cnt == 0) begin
                ALU_OUT     = alu_res;
                ALU_OUT_VLD = 1'b1;
            end
        end
        FIFO_FULL = ff_force || (ff_rand && $urandom_range(0, 2) == 0);
        @(negedge CLK);
        if (RST) monitor();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_byte = b;
        rx_pend = 1'b1;
        tick();
        repeat (gap) tick();
    endtask

    task automatic send_frame(input logic rand_gap);
        foreach (frm[i]) send_byte(frm[i], rand_gap ? $urandom_range(1, 3) : 1);
    endtask

    task automatic model_alu(input logic [7:0] fb);
        logic [3:0]  f;
        logic [15:0] r;
        f = fb[3:0];
        exp_alu.push_back(int'(f));
        r = alu_fn(ref_mem[0], ref_mem[1], f);
        exp_tx.push_back(int'(r[7:0]));
        exp_tx.push_back(int'(r[15:8]));
    endtask

    task automatic model_frame();
        logic [7:0] b0, b1, b2, b3;
        logic [3:0] a;
        b0 = frm[0];
        b1 = (frm.size() > 1) ? frm[1] : 8'h00;
        b2 = (frm.size() > 2) ? frm[2] : 8'h00;
        b3 = (frm.size() > 3) ? frm[3] : 8'h00;
        a  = b1[3:0];
        case (b0)
            8'hAA: begin
                exp_wr.push_back((int'(a) << 8) | int'(b2));
                ref_mem[a] = b2;
            end
            8'hBB: begin
                exp_rd.push_back(int'(a));
                exp_tx.push_back(int'(ref_mem[a]));
            end
            8'hCC: begin
                exp_wr.push_back(int'(b1));
                exp_wr.push_back((1 << 8) | int'(b2));
                ref_mem[0] = b1;
                ref_mem[1] = b2;
                model_alu(b3);
            end
            8'hDD: model_alu(b1);
            8'hEE: begin
                for (int i = 0; i < int'(b2); i++) begin
                    exp_rd.push_back((int'(a) + i) % 16);
                    exp_tx.push_back(int'(ref_mem[(int'(a) + i) % 16]));
                end
            end
            default: err_exp++;
        endcase
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!idle() && n < 1000) begin
            tick();
            n++;
        end
        check("idle_reached", 32'(idle()), 32'd1);
        repeat (4) tick();
    endtask

    task automatic run_frame(input logic rand_gap);
        model_frame();
        send_frame(rand_gap);
        wait_idle();
    endtask

    task automatic flush_model();
        wr_i = exp_wr.size(); rd_i = exp_rd.size(); alu_i = exp_alu.size(); tx_i = exp_tx.size();
        err_seen = err_exp;
        rd_req = 1'b0; alu_cnt = 0; exp_clk = 1'b0; prev_vld = 1'b0; rx_pend = 1'b0;
    endtask

    initial begin
        int tx0;
        logic [7:0] b;
        RST = 1'b0; RX_P_DATA = '0; RX_D_VLD = 1'b0; RdData = '0; RdData_Valid = 1'b0;
        ALU_OUT = '0; ALU_OUT_VLD = 1'b0; FIFO_FULL = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 8'($urandom);
            rf_mem[i]  = ref_mem[i];
        end

        repeat (3) tick();
        check("reset_outputs", 32'({WrEN, RdEN, Address, WrData, ALU_EN, ALU_FUN, CLK_EN,
                                   clk_div_en, WR_DATA, WR_INC, CMD_ERR}), 32'd0);
        #2 RST = 1'b1;
        tick();
        check("clk_div_en_after_reset", 32'(clk_div_en), 32'd1);

        frm = '{8'hAA, 8'h05, 8'h3C};          run_frame(1'b0);
        frm = '{8'hBB, 8'h05};                 run_frame(1'b0);
        frm = '{8'hCC, 8'h0A, 8'h03, 8'h00};   run_frame(1'b0);

        frm = '{8'hAA, 8'h0E, 8'h71};          run_frame(1'b0);
        frm = '{8'hAA, 8'h0F, 8'h72};          run_frame(1'b0);
        tx0 = tx_seen;
        frm = '{8'hEE, 8'h0E, 8'h03};
        model_frame();
        send_frame(1'b0);
        repeat (3) tick();
        ff_force = 1'b1;
        repeat (10) tick();
        ff_force = 1'b0;
        wait_idle();
        check("burst_push_count", 32'(tx_seen - tx0), 32'd3);

        frm = '{8'h55};                        run_frame(1'b0);
        frm = '{8'hDD, 8'h02};
        model_frame();
        send_byte(8'hDD, 2);
        send_byte(8'h02, 1);
        err_exp++;
        send_byte(8'h11, 1);
        wait_idle();
        check("cmd_err_count", 32'(err_seen), 32'd2);

        frm = '{8'hEE, 8'h00, 8'h06};
        model_frame();
        send_frame(1'b0);
        repeat (10) tick();
        #2 RST = 1'b0;
        #1;
        check("rst_strobes", 32'({WrEN, RdEN, ALU_EN, CLK_EN, WR_INC, CMD_ERR}), 32'd0);
        check("rst_clk_div_en", 32'(clk_div_en), 32'd0);
        flush_model();
        repeat (3) tick();
        #2 RST = 1'b1;
        tick();
        check("clk_div_en_after_rerelease", 32'(clk_div_en), 32'd1);
        frm = '{8'hBB, 8'h02};                 run_frame(1'b0);

        ff_rand = 1'b1;
        repeat (60) begin
            case ($urandom_range(0, 5))
                0: frm = '{8'hAA, 8'($urandom), 8'($urandom)};
                1: frm = '{8'hBB, 8'($urandom)};
                2: frm = '{8'hCC, 8'($urandom), 8'($urandom), 8'($urandom)};
                3: frm = '{8'hDD, 8'($urandom)};
                4: frm = '{8'hEE, 8'($urandom), 8'($urandom_range(0, 5))};
                default: begin
                    do b = 8'($urandom);
                    while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD || b == 8'hEE);
                    frm = '{b};
                end
            endcase
            run_frame(1'b1);
        end
        ff_rand = 1'b0;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/sys_ctrl_burst.md
Name: sys_ctrl_burst

Overview:
- Parametrised successor to the current system controller, running in the REF_CLK domain.
- Decodes command frames arriving as synchronised UART RX bytes, and drives the register file and the ALU (including the ALU clock-gate enable).
- Serialises responses into the TX async FIFO, and respects FIFO_FULL back-pressure.
- New over the previous generation: generic data/address widths, multi-byte ALU results, a burst-read command, and a command-error flag.

Parameters:
- DATA_WIDTH, 8: byte width of RX/TX, RF data, and ALU operands.
- ADDR_WIDTH, 4: register-file address width.
- ALU_OUT_BYTES, 2: ALU result width is DATA_WIDTH*ALU_OUT_BYTES; bytes sent per ALU response.
- ALU_FUN_WIDTH, 4: ALU function code width.

Ports:
- CLK  in  1  REF_CLK domain clock
- RST  in  1  asynchronous active-low reset
- RX_P_DATA  in  DATA_WIDTH  synchronised received byte
- RX_D_VLD  in  1  one-cycle pulse: RX_P_DATA valid
- RdData  in  DATA_WIDTH  register-file read data
- RdData_Valid  in  1  register-file read data valid
- WrEN  out  1  RF write strobe
- RdEN  out  1  RF read strobe
- Address  out  ADDR_WIDTH  RF address
- WrData  out  DATA_WIDTH  RF write data
- ALU_EN  out  1  ALU operation strobe
- ALU_FUN  out  ALU_FUN_WIDTH  ALU function code
- ALU_OUT  in  DATA_WIDTH*ALU_OUT_BYTES  ALU result
- ALU_OUT_VLD  in  1  ALU result valid
- CLK_EN  out  1  ALU clock-gate enable
- clk_div_en  out  1  UART clock-divider enable
- FIFO_FULL  in  1  TX FIFO full
- WR_DATA  out  DATA_WIDTH  TX FIFO write data
- WR_INC  out  1  TX FIFO push strobe
- CMD_ERR  out  1  one-cycle pulse: frame byte rejected

Behaviour:
- Reset (RST=0, asynchronous):
  - FSM returns to IDLE.
  - All outputs are 0, except clk_div_en.
  - clk_div_en is 0 during reset and 1 from the first clock after reset release.
  - Reset mid-frame or mid-transmission abandons the operation with no further strobes.
- Commands (first byte of a frame, decoded in IDLE):
  - 0xAA: RF write, frame AA, addr, data.
  - 0xBB: RF read, frame BB, addr.
  - 0xCC: ALU with operands, frame CC, A, B, fun.
  - 0xDD: ALU without operands, frame DD, fun.
  - 0xEE: burst read, frame EE, addr, N.
  - Any other byte in IDLE: CMD_ERR pulses, state stays IDLE.
  - Address bytes use the low ADDR_WIDTH bits. Function bytes use the low ALU_FUN_WIDTH bits.
- FSM states:
  - IDLE
  - WR_ADDR → WR_DATA
  - RD_ADDR → RD_WAIT
  - OPA → OPB → FUN → ALU_WAIT
  - BR_ADDR → BR_CNT → BR_RD → BR_WAIT
  - TX (shared response sender)
  - Each frame byte advances the FSM on its RX_D_VLD.
- RF write (AA): on the data byte, WrEN=1 for exactly one cycle with the latched Address and WrData; then IDLE.
- RF read (BB):
  - On the addr byte, RdEN=1 for one cycle.
  - In RD_WAIT, on RdData_Valid, latch RdData and go to TX (1 byte).
- Operand writes (CC only):
  - Byte A is written to RF address 0 (one-cycle WrEN on receipt).
  - Byte B is written to RF address 1 (one-cycle WrEN on receipt).
- ALU op (CC/DD fun byte):
  - ALU_FUN is latched.
  - CLK_EN rises in the same cycle as ALU_EN (one-cycle pulse).
  - CLK_EN stays high until ALU_OUT_VLD is seen in ALU_WAIT.
  - ALU_OUT is captured, then TX with ALU_OUT_BYTES bytes, least-significant byte first.
  - CLK_EN drops the cycle after capture.
- Burst read (EE):
  - N=0: no reads, no response, back to IDLE.
  - N>0: N sequential RF reads starting at addr.
  - Address increments modulo 2^ADDR_WIDTH, so 0xF wraps to 0x0 for ADDR_WIDTH=4.
  - Each read (RdEN pulse, wait RdData_Valid) is followed by its TX byte before the next RdEN.
- TX sender:
  - WR_INC is asserted for one cycle with WR_DATA valid only when FIFO_FULL=0.
  - While FIFO_FULL=1, WR_INC stays 0 and WR_DATA holds.
  - No byte is ever dropped or duplicated.
- RX_D_VLD in RD_WAIT, ALU_WAIT, BR_RD, BR_WAIT or TX: the byte is dropped, CMD_ERR pulses, and the current operation continues.
- No watchdog timeout is implemented: the FSM waits indefinitely for valid strobes.

Test Plan:
- Reset, then frame AA,05,3C → one WrEN pulse with Address=5, WrData=0x3C; CMD_ERR=0; clk_div_en=1.
- After the write, frame BB,05; RF returns 0x3C → RdEN pulse at address 5; one WR_INC with WR_DATA=0x3C.
- Frame CC,0A,03,00 (add); ALU returns 0x000D →
  - RF writes: addr0=0x0A, addr1=0x03.
  - ALU_EN=1 pulse with ALU_FUN=0; CLK_EN high from the ALU_EN cycle until capture.
  - WR_DATA sequence 0x0D then 0x00.
- Frame EE,0E,03 with FIFO_FULL forced 1 for 10 cycles mid-burst →
  - Reads at addresses 0xE, 0xF, 0x0.
  - Exactly 3 WR_INC pulses in order.
  - No WR_INC while FIFO_FULL=1.
- Byte 0x55 in IDLE, then byte 0x11 during ALU_WAIT → two CMD_ERR pulses; FSM completes the pending ALU response unchanged.
- RST asserted low in the middle of an EE burst → all strobes are 0 immediately; after release, frame BB,02 executes normally.
